// File: rtl/boid_frame_scheduler.sv
// -----------------------------------------------------------------------------
// boid_frame_scheduler
//
// Once-per-frame refresh sequencer for the boid display memory. An end-of-frame
// pulse starts a scan:
//   1. One clear cycle to the resettable display RAM.
//   2. A walk over every BPU through the read-select.
//   3. A display-RAM write of the linear pixel address for each on-screen boid.
//   4. One done cycle.
// Off-screen boids are counted instead of written.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset, overrides everything
//   enable      in   gates the start of a new scan
//   frame_end   in   one-cycle end-of-frame pulse from the VGA controller
//   boid_x      in   x of the selected boid (combinational from the BPU mux)
//   boid_y      in   y of the selected boid
//   boid_sel    out  index of the BPU being read
//   disp_clear  out  one-cycle clear pulse to the display RAM
//   disp_we     out  display-RAM write enable (write data is always 1)
//   disp_addr   out  display-RAM write address
//   busy        out  high from the clear cycle through the done cycle
//   frame_done  out  one-cycle pulse in the done cycle
//   overrun     out  sticky, set by a frame_end that arrives while busy
//   skip_count  out  off-screen boids in the current/last scan, saturating
// -----------------------------------------------------------------------------
module boid_frame_scheduler #(
   parameter int MAX_BOIDS      = 4,
   parameter int BITS_FOR_BOIDS = (MAX_BOIDS > 1) ? $clog2(MAX_BOIDS) : 1,
   parameter int VIDEO_WIDTH    = 640,
   parameter int VIDEO_HEIGHT   = 480,
   parameter int ADDR_WIDTH     = 19
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      frame_end,
   input  logic [9:0]                boid_x,
   input  logic [8:0]                boid_y,
   output logic [BITS_FOR_BOIDS-1:0] boid_sel,
   output logic                      disp_clear,
   output logic                      disp_we,
   output logic [ADDR_WIDTH-1:0]     disp_addr,
   output logic                      busy,
   output logic                      frame_done,
   output logic                      overrun,
   output logic [7:0]                skip_count
);

   typedef enum logic [1:0] {IDLE, CLEAR, SCAN, DONE} state_t;

   localparam logic [BITS_FOR_BOIDS-1:0] LAST_SEL = BITS_FOR_BOIDS'(MAX_BOIDS - 1);

   state_t                      state, state_next;
   logic                        start, last_boid, on_screen;
   logic [ADDR_WIDTH-1:0]       pix_addr;

   // Next values of the registered outputs
   logic [BITS_FOR_BOIDS-1:0]   sel_d;
   logic [ADDR_WIDTH-1:0]       addr_d;
   logic [7:0]                  skip_d;
   logic                        we_d, clear_d, busy_d, done_d, overrun_d;

   assign start     = (state == IDLE) && frame_end && enable;
   assign last_boid = (boid_sel == LAST_SEL);
   assign on_screen = (int'(boid_x) < VIDEO_WIDTH) && (int'(boid_y) < VIDEO_HEIGHT);
   // Multiplication by a constant width reduces to shifts and adds in synthesis.
   assign pix_addr  = ADDR_WIDTH'(boid_y) * ADDR_WIDTH'(VIDEO_WIDTH) + ADDR_WIDTH'(boid_x);

   // State and output registers
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         boid_sel   <= '0;
         disp_addr  <= '0;
         skip_count <= '0;
         disp_we    <= 1'b0;
         disp_clear <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_next;
         boid_sel   <= sel_d;
         disp_addr  <= addr_d;
         skip_count <= skip_d;
         disp_we    <= we_d;
         disp_clear <= clear_d;
         busy       <= busy_d;
         frame_done <= done_d;
         overrun    <= overrun_d;
      end
   end

   // Next-state logic
   // NOTE: the default assignment at the top keeps this block free of latches.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = CLEAR;
         CLEAR:   state_next = SCAN;
         SCAN:    if (last_boid) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      sel_d     = boid_sel;
      addr_d    = disp_addr;
      skip_d    = skip_count;
      we_d      = 1'b0;
      // A frame_end outside IDLE is only recorded, never acted on.
      overrun_d = overrun | (frame_end && (state != IDLE));
      clear_d   = (state_next == CLEAR);
      busy_d    = (state_next != IDLE);
      done_d    = (state_next == DONE);
      unique case (state)
         IDLE: begin
            if (start) begin
               sel_d  = '0;
               skip_d = '0;
            end
         end
         SCAN: begin
            if (on_screen) begin
               we_d   = 1'b1;
               addr_d = pix_addr;
            end else if (skip_count != 8'hFF) begin
               skip_d = skip_count + 8'd1;
            end
            sel_d = last_boid ? '0 : boid_sel + BITS_FOR_BOIDS'(1);
         end
         default: ;
      endcase
   end

endmodule
